// File: rtl/bp_lce_cache_pkt_arb_pkg.sv
// Shared types for the LCE cache packet arbiter: lock states and one-hot grant owner.
package bp_lce_cache_pkt_arb_pkg;

    typedef enum logic [1:0] {
        e_idle      = 2'd0,
        e_lock_fill = 2'd1,
        e_lock_cmd  = 2'd2
    } bp_lce_arb_state_e;

    // One-hot {cmd, fill}; matches the owner_o bit layout.
    typedef enum logic [1:0] {
        e_owner_none = 2'b00,
        e_owner_fill = 2'b01,
        e_owner_cmd  = 2'b10
    } bp_lce_arb_owner_e;

    localparam int starve_cnt_width_lp = 8;

endpackage

// File: rtl/bp_lce_arb_starve_cnt.sv
// Saturating clear/up counter tracking how long Command has waited behind Fill.
module bp_lce_arb_starve_cnt #(
    parameter int width_p = 8,
    parameter int limit_p = 15
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic up_i,
    output logic at_limit_o
);

    localparam logic [width_p-1:0] limit_lp = width_p'(limit_p);

    logic [width_p-1:0] count_r;

    // Clear wins over increment; the count holds once it reaches the limit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (up_i && (count_r != limit_lp)) begin
            count_r <= count_r + 1'b1;
        end
    end

    assign at_limit_o = (count_r == limit_lp);

endmodule

// File: rtl/bp_lce_cache_pkt_arb.sv
// Transaction-atomic arbiter of the cache tag/data mem packet ports between LCE Fill and Command.
//   state       | meaning
//   e_idle      | no lock; arbitrate every cycle, grant not held unless a non-last packet is taken
//   e_lock_fill | Fill owns both channels until it retires a last packet
//   e_lock_cmd  | Command owns both channels until it retires a last packet
module bp_lce_cache_pkt_arb
    import bp_lce_cache_pkt_arb_pkg::*;
#(
    parameter int tag_pkt_width_p  = 8,
    parameter int data_pkt_width_p = 16,
    parameter int starve_limit_p   = 15
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        fill_tag_pkt_v_i,
    input  logic [tag_pkt_width_p-1:0]  fill_tag_pkt_i,
    input  logic                        fill_tag_last_i,
    output logic                        fill_tag_pkt_yumi_o,
    input  logic                        fill_data_pkt_v_i,
    input  logic [data_pkt_width_p-1:0] fill_data_pkt_i,
    input  logic                        fill_data_last_i,
    output logic                        fill_data_pkt_yumi_o,

    input  logic                        cmd_tag_pkt_v_i,
    input  logic [tag_pkt_width_p-1:0]  cmd_tag_pkt_i,
    input  logic                        cmd_tag_last_i,
    output logic                        cmd_tag_pkt_yumi_o,
    input  logic                        cmd_data_pkt_v_i,
    input  logic [data_pkt_width_p-1:0] cmd_data_pkt_i,
    input  logic                        cmd_data_last_i,
    output logic                        cmd_data_pkt_yumi_o,

    output logic                        tag_mem_pkt_v_o,
    output logic [tag_pkt_width_p-1:0]  tag_mem_pkt_o,
    input  logic                        tag_mem_pkt_yumi_i,
    output logic                        data_mem_pkt_v_o,
    output logic [data_pkt_width_p-1:0] data_mem_pkt_o,
    input  logic                        data_mem_pkt_yumi_i,

    output logic                        busy_o,
    output logic [1:0]                  owner_o
);

    bp_lce_arb_state_e state_r;
    bp_lce_arb_owner_e owner;
    logic fill_req, cmd_req, starve_at_limit;
    logic tag_last, data_last, tag_accept, data_accept, any_accept, last_accept;

    assign fill_req = fill_tag_pkt_v_i | fill_data_pkt_v_i;
    assign cmd_req  = cmd_tag_pkt_v_i  | cmd_data_pkt_v_i;

    // Reset gates the grant itself so every output drops asynchronously.
    always_comb begin
        owner = e_owner_none;
        unique case (state_r)
            e_idle: begin
                if (cmd_req && (!fill_req || starve_at_limit)) owner = e_owner_cmd;
                else if (fill_req)                             owner = e_owner_fill;
            end
            e_lock_fill: owner = e_owner_fill;
            e_lock_cmd:  owner = e_owner_cmd;
            default:     owner = e_owner_none;
        endcase
        if (!reset_n_i) owner = e_owner_none;
    end

    always_comb begin
        tag_mem_pkt_v_o  = 1'b0;
        tag_mem_pkt_o    = '0;
        tag_last         = 1'b0;
        data_mem_pkt_v_o = 1'b0;
        data_mem_pkt_o   = '0;
        data_last        = 1'b0;
        unique case (owner)
            e_owner_fill: begin
                tag_mem_pkt_v_o  = fill_tag_pkt_v_i;
                tag_mem_pkt_o    = fill_tag_pkt_i;
                tag_last         = fill_tag_last_i;
                data_mem_pkt_v_o = fill_data_pkt_v_i;
                data_mem_pkt_o   = fill_data_pkt_i;
                data_last        = fill_data_last_i;
            end
            e_owner_cmd: begin
                tag_mem_pkt_v_o  = cmd_tag_pkt_v_i;
                tag_mem_pkt_o    = cmd_tag_pkt_i;
                tag_last         = cmd_tag_last_i;
                data_mem_pkt_v_o = cmd_data_pkt_v_i;
                data_mem_pkt_o   = cmd_data_pkt_i;
                data_last        = cmd_data_last_i;
            end
            default: ;
        endcase
    end

    assign tag_accept  = tag_mem_pkt_v_o  & tag_mem_pkt_yumi_i;
    assign data_accept = data_mem_pkt_v_o & data_mem_pkt_yumi_i;
    assign any_accept  = tag_accept | data_accept;
    assign last_accept = (tag_accept & tag_last) | (data_accept & data_last);

    assign fill_tag_pkt_yumi_o  = (owner == e_owner_fill) & tag_accept;
    assign fill_data_pkt_yumi_o = (owner == e_owner_fill) & data_accept;
    assign cmd_tag_pkt_yumi_o   = (owner == e_owner_cmd)  & tag_accept;
    assign cmd_data_pkt_yumi_o  = (owner == e_owner_cmd)  & data_accept;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
        end else begin
            unique case (state_r)
                e_idle: begin
                    if (any_accept && !last_accept)
                        state_r <= (owner == e_owner_cmd) ? e_lock_cmd : e_lock_fill;
                end
                e_lock_fill, e_lock_cmd: begin
                    if (last_accept) state_r <= e_idle;
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    assign busy_o  = (state_r != e_idle);
    assign owner_o = owner;

    bp_lce_arb_starve_cnt #(
        .width_p (starve_cnt_width_lp),
        .limit_p (starve_limit_p)
    ) starve_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .clear_i    (cmd_tag_pkt_yumi_o | cmd_data_pkt_yumi_o),
        .up_i       (cmd_req & (owner == e_owner_fill)),
        .at_limit_o (starve_at_limit)
    );

endmodule
